// File: rtl/ddr_phase_stepper.sv
// ddr_phase_stepper
// Walks the DDR read-clock PLL's dynamic phase shift from its current index to a
// requested index. Each step is a phase_step pulse, a fixed settle gap, and a wait
// for the PLL to re-lock. The block tracks the current phase modulo 2^PHASE_BITS,
// pulses done when a request completes, and latches err on a lock timeout.
//
// Optional feature macro: PHASE_SHORTEST_PATH_EN
//   defined   - take the shorter direction round the phase circle (tie steps up)
//   undefined - always step up
module ddr_phase_stepper #(
    parameter int PHASE_BITS   = 4,
    parameter int PULSE_LEN    = 2,
    parameter int STEP_GAP     = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int INIT_PHASE   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [PHASE_BITS-1:0] req_phase,
    output logic                  req_ready,
    input  logic                  err_clr,
    input  logic                  pll_locked,
    output logic                  phase_step,
    output logic                  phase_updn,
    output logic [PHASE_BITS-1:0] cur_phase,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // One counter serves both the pulse-high and the gap-low phases.
    localparam int CNT_MAX = (PULSE_LEN > STEP_GAP) ? PULSE_LEN : STEP_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Timer holds 0 .. LOCK_TIMEOUT-1.
    localparam int TMR_W   = $clog2(LOCK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_WAIT_LOCK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_reg;
    logic                    phase_step_reg;
    logic                    phase_updn_reg;
    logic [PHASE_BITS-1:0]   cur_phase_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic [PHASE_BITS-1:0]   remain_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [TMR_W-1:0]        timer_reg;

    logic [PHASE_BITS-1:0]   diff_next;
    logic [PHASE_BITS-1:0]   step_cnt_next;
    logic                    step_up_next;
    logic                    req_ready_int;

    // Ready and busy are pure state decodes so the requester sees them without delay.
    assign req_ready_int = (state_reg == S_IDLE) && pll_locked && !err_reg;
    assign req_ready     = req_ready_int;
    assign busy          = (state_reg != S_IDLE) && (state_reg != S_ERROR);

    assign phase_step = phase_step_reg;
    assign phase_updn = phase_updn_reg;
    assign cur_phase  = cur_phase_reg;
    assign done       = done_reg;
    assign err        = err_reg;

`ifdef PHASE_SHORTEST_PATH_EN
    localparam logic [PHASE_BITS-1:0] HALF_STEPS = PHASE_BITS'(2 ** (PHASE_BITS - 1));

    // Step count and direction for a new request: shorter way round, tie goes up.
    always_comb begin
        diff_next     = req_phase - cur_phase_reg;
        step_up_next  = 1'b1;
        step_cnt_next = diff_next;
        if (diff_next > HALF_STEPS) begin
            step_up_next  = 1'b0;
            step_cnt_next = PHASE_BITS'(0) - diff_next;
        end
    end
`else
    // Step count and direction for a new request: always walk upwards.
    always_comb begin
        diff_next     = req_phase - cur_phase_reg;
        step_up_next  = 1'b1;
        step_cnt_next = diff_next;
    end
`endif

    // Sequencer: pulse, settle gap, wait for re-lock, repeat until the count runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            phase_step_reg <= 1'b0;
            phase_updn_reg <= 1'b0;
            cur_phase_reg  <= PHASE_BITS'(INIT_PHASE);
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            remain_reg     <= '0;
            cnt_reg        <= '0;
            timer_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready_int) begin
                        remain_reg <= step_cnt_next;
                        cnt_reg    <= '0;
                        if (step_cnt_next == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg      <= S_PULSE;
                            phase_step_reg <= 1'b1;
                            phase_updn_reg <= step_up_next;
                        end
                    end
                end
                S_PULSE: begin
                    if (cnt_reg == CNT_W'(PULSE_LEN - 1)) begin
                        // The PLL moves on this pulse, so the tracked phase moves with it.
                        phase_step_reg <= 1'b0;
                        cur_phase_reg  <= phase_updn_reg ? cur_phase_reg + PHASE_BITS'(1)
                                                         : cur_phase_reg - PHASE_BITS'(1);
                        remain_reg     <= remain_reg - PHASE_BITS'(1);
                        cnt_reg        <= '0;
                        state_reg      <= S_GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_reg == CNT_W'(STEP_GAP - 1)) begin
                        timer_reg <= '0;
                        state_reg <= S_WAIT_LOCK;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock is checked before the timeout so a lock on the expiry edge wins.
                    if (pll_locked) begin
                        if (remain_reg != '0) begin
                            state_reg      <= S_PULSE;
                            phase_step_reg <= 1'b1;
                            cnt_reg        <= '0;
                        end else begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end
                    end else if (timer_reg == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        state_reg <= S_ERROR;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                S_ERROR: begin
                    if (err_clr) begin
                        err_reg   <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_phase_stepper.sv
// Bench for ddr_phase_stepper: a table of phase requests checked through a
// scoreboard queue by a pulse monitor, plus hand sequences for lock timeout,
// lock-on-expiry, error clear and reset mid-pulse.
module tb_ddr_phase_stepper;

    localparam int PB = 4;
    localparam int PULSE_LEN = 2;
    localparam int STEP_GAP = 8;
    localparam int LOCK_TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [PB-1:0] req_phase = '0;
    logic          req_ready;
    logic          err_clr = 1'b0;
    logic          pll_locked = 1'b1;
    logic          phase_step;
    logic          phase_updn;
    logic [PB-1:0] cur_phase;
    logic          busy;
    logic          done;
    logic          err;

    ddr_phase_stepper #(
        .PHASE_BITS(PB),
        .PULSE_LEN(PULSE_LEN),
        .STEP_GAP(STEP_GAP),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .INIT_PHASE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_phase(req_phase),
        .req_ready(req_ready),
        .err_clr(err_clr),
        .pll_locked(pll_locked),
        .phase_step(phase_step),
        .phase_updn(phase_updn),
        .cur_phase(cur_phase),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PB-1:0] target;
        int            pulses;
        logic          up;
        logic [PB-1:0] final_phase;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 3000) begin
            tick();
            k++;
        end
        check("ready_wait", req_ready, 1);
    endtask

    task automatic wait_pulse_end();
        int k = 0;
        while (phase_step && k < 50) begin
            tick();
            k++;
        end
        check("pulse_end", phase_step, 0);
    endtask

    // Monitor: measures pulse/gap widths, models cur_phase per pulse, and retires
    // scoreboard entries on done.
    logic          prev_step = 1'b0;
    int            hi_len = 0;
    int            low_len = 0;
    int            pulses = 0;
    logic [PB-1:0] mdl_phase = 4'd4;
    vec_t          exp_v;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    if (phase_step || done) check("sb_nonempty", 0, 1);
                end else begin
                    exp_v = sb_q[0];
                    if (phase_step) begin
                        if (!prev_step) begin
                            if (pulses > 0) check("gap_len", low_len, STEP_GAP + 1);
                            hi_len = 0;
                        end
                        hi_len++;
                        low_len = 0;
                        check("updn_in_pulse", phase_updn, exp_v.up);
                    end else begin
                        if (prev_step) begin
                            check("pulse_len", hi_len, PULSE_LEN);
                            pulses++;
                            mdl_phase = exp_v.up ? mdl_phase + 4'd1 : mdl_phase - 4'd1;
                            check("step_phase", cur_phase, mdl_phase);
                            low_len = 0;
                        end
                        low_len++;
                    end
                    if (done) begin
                        check("pulse_count", pulses, exp_v.pulses);
                        check("final_phase", cur_phase, exp_v.final_phase);
                        if (exp_v.pulses > 0) check("updn_at_done", phase_updn, exp_v.up);
                        $display("[TB] req target=%0d pulses=%0d cur_phase=%0d updn=%0d",
                                 exp_v.target, pulses, cur_phase, phase_updn);
                        void'(sb_q.pop_front());
                        pulses = 0;
                        low_len = 0;
                        done_cnt++;
                    end
                end
            end
            prev_step = phase_step;
        end
    end

    initial begin
        int saved;
        int k;
        logic [PB-1:0] tgt;
        logic [PB-1:0] base;

        // target, pulses, up, final
`ifdef PHASE_SHORTEST_PATH_EN
        vecs[0] = '{4'd2,  2,  1'b0, 4'd2};
        vecs[4] = '{4'd15, 1,  1'b0, 4'd15};
`else
        vecs[0] = '{4'd2,  14, 1'b1, 4'd2};
        vecs[4] = '{4'd15, 15, 1'b1, 4'd15};
`endif
        vecs[1] = '{4'd8,  6,  1'b1, 4'd8};
        vecs[2] = '{4'd8,  0,  1'b1, 4'd8};
        vecs[3] = '{4'd0,  8,  1'b1, 4'd0};
        vecs[5] = '{4'd1,  2,  1'b1, 4'd1};
        vecs[6] = '{4'd9,  8,  1'b1, 4'd9};

        // Reset state while rst_n is held low.
        #12;
        check("rst_step", phase_step, 0);
        check("rst_phase", cur_phase, 4);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_updn", phase_updn, 0);
        #11 rst_n = 1'b1;
        tick();
        check("rst_ready", req_ready, 1);
        $display("[TB] reset: cur_phase=%0d req_ready=%0d", cur_phase, req_ready);

        // Table-driven requests with lock held high.
        mon_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_ready();
            saved = done_cnt;
            req_valid = 1'b1;
            req_phase = vecs[i].target;
            sb_q.push_back(vecs[i]);
            tick();
            req_valid = 1'b0;
            check("accept_busy", busy, 1);
            check("accept_step", phase_step, (vecs[i].pulses != 0) ? 1 : 0);
            check("accept_done", done, (vecs[i].pulses == 0) ? 1 : 0);
            if (vecs[i].pulses == 0) begin
                tick();
                check("zero_ready_n2", req_ready, 1);
                check("zero_done_1cyc", done, 0);
            end
            k = 0;
            while (done_cnt == saved && k < 3000) begin
                tick();
                k++;
            end
            check("done_seen", (done_cnt != saved) ? 1 : 0, 1);
        end
        mon_en = 1'b0;
        tick();

        // Lock timeout after the first of three steps.
        base = vecs[6].final_phase;
        tgt = base + 4'd3;
        wait_ready();
        req_valid = 1'b1;
        req_phase = tgt;
        tick();
        req_valid = 1'b0;
        wait_pulse_end();
        pll_locked = 1'b0;
        k = 0;
        while (!err && k < LOCK_TIMEOUT + STEP_GAP + 100) begin
            tick();
            k++;
        end
        check("timeout_latency", k, STEP_GAP + LOCK_TIMEOUT);
        check("timeout_err", err, 1);
        check("timeout_ready", req_ready, 0);
        check("timeout_busy", busy, 0);
        check("timeout_phase", cur_phase, base + 4'd1);
        $display("[TB] timeout: err=%0d cur_phase=%0d after %0d cycles", err, cur_phase, k);
        pll_locked = 1'b1;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (phase_step) k++;
        end
        check("error_no_pulse", k, 0);
        check("error_ready_locked", req_ready, 0);
        pll_locked = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", err, 0);
        check("clr_busy", busy, 0);
        check("clr_ready_nolock", req_ready, 0);
        pll_locked = 1'b1;
        #1;
        check("clr_ready_lock", req_ready, 1);
        $display("[TB] err_clr: err=%0d req_ready=%0d", err, req_ready);

        // Lock arriving on the timeout edge wins.
        base = base + 4'd1;
        wait_ready();
        req_valid = 1'b1;
        req_phase = base + 4'd1;
        tick();
        req_valid = 1'b0;
        wait_pulse_end();
        pll_locked = 1'b0;
        repeat (STEP_GAP + LOCK_TIMEOUT - 1) @(posedge clk);
        #1;
        check("edge_pre_err", err, 0);
        check("edge_pre_busy", busy, 1);
        pll_locked = 1'b1;
        tick();
        check("edge_lock_err", err, 0);
        check("edge_lock_done", done, 1);
        check("edge_lock_phase", cur_phase, base + 4'd1);
        $display("[TB] lock-on-expiry: err=%0d done=%0d cur_phase=%0d", err, done, cur_phase);

        // Asynchronous reset in the middle of a pulse.
        wait_ready();
        req_valid = 1'b1;
        req_phase = base + 4'd3;
        tick();
        req_valid = 1'b0;
        check("mid_step_high", phase_step, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_step", phase_step, 0);
        check("mid_rst_phase", cur_phase, 4);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_busy", busy, 0);
        $display("[TB] reset mid-pulse: phase_step=%0d cur_phase=%0d", phase_step, cur_phase);
        #4 rst_n = 1'b1;
        tick();
        check("post_rst_ready", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
